// File: rtl/encoder_pkg.sv
// Shared opcode constants, request-op enum and the field-to-word packer for the
// MIPS instruction loader; the control decoder takes its opcode values from here.
package encoder_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BRNV  = 6'b010101;
    localparam logic [5:0] OPC_ORI   = 6'b001101;

    typedef enum logic [2:0] {
        OP_RTYPE = 3'd0,
        OP_LW    = 3'd1,
        OP_SW    = 3'd2,
        OP_BEQ   = 3'd3,
        OP_BRNV  = 3'd4,
        OP_ORI   = 3'd5
    } req_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= 3'd5);
    endfunction

    // I-type words ignore rd, shamt and funct; illegal ops pack to zero.
    function automatic logic [31:0] encode(
        input logic [2:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [15:0] imm
    );
        logic [31:0] word;
        case (op)
            OP_RTYPE: word = {OPC_RTYPE, rs, rt, rd, shamt, funct};
            OP_LW:    word = {OPC_LW,   rs, rt, imm};
            OP_SW:    word = {OPC_SW,   rs, rt, imm};
            OP_BEQ:   word = {OPC_BEQ,  rs, rt, imm};
            OP_BRNV:  word = {OPC_BRNV, rs, rt, imm};
            OP_ORI:   word = {OPC_ORI,  rs, rt, imm};
            default:  word = 32'h0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data; clear empties it in one cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs field-level instruction requests into 32-bit words, queues them and
// writes them to instruction memory at consecutive word addresses.
module instr_encoder
    import encoder_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_shamt,
    input  logic [5:0]        req_funct,
    input  logic [15:0]       req_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic [ADDR_W:0]   wr_count,
    output logic              err_illegal,
    output logic              busy
);

    localparam logic [ADDR_W:0] WR_MAX = {1'b1, {ADDR_W{1'b0}}};

    wr_state_e state_q, state_d;

    logic        accept;
    logic        push;
    logic        pop;
    logic [31:0] enc_word;
    logic [31:0] fifo_rdata;
    logic        fifo_full;
    logic        fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    // Request side: a request transfers on any cycle where req_valid && req_ready;
    // req_valid may not wait on req_ready. Memory side: mem_we/addr/wdata stay
    // stable until a cycle with mem_ack, which completes that write.
    assign req_ready = !fifo_full && !flush && !reset;
    assign accept    = req_valid && req_ready;
    assign push      = accept && op_legal(req_op);
    assign enc_word  = encode(req_op, req_rs, req_rt, req_rd, req_shamt, req_funct, req_imm);

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .wdata (enc_word),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_WRITE;
                    pop     = 1'b1;
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            pop     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    assign mem_we = (state_q == ST_WRITE);
    assign busy   = !fifo_empty || mem_we;

    // Flush discards the in-flight word even when mem_ack lands in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            mem_addr  <= ADDR_W'(BASE_ADDR);
            mem_wdata <= 32'h0;
            wr_count  <= '0;
        end else begin
            if (mem_we && mem_ack) begin
                mem_addr <= mem_addr + 1'b1;
                if (wr_count != WR_MAX) wr_count <= wr_count + 1'b1;
            end
            if (pop) mem_wdata <= fifo_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) err_illegal <= 1'b0;
        else       err_illegal <= accept && !op_legal(req_op);
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: expected {addr, word} pairs are queued at
// request acceptance and checked by a monitor on every acknowledged write.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [4:0]  req_rs = '0, req_rt = '0, req_rd = '0, req_shamt = '0;
    logic [5:0]  req_funct = '0;
    logic [15:0] req_imm = '0;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [8:0]  wr_count;
    logic        err_illegal;
    logic        busy;

    int tests = 0;
    int fails = 0;

    logic [39:0] exp_q[$];
    logic [7:0]  exp_addr = 8'h00;
    logic [39:0] exp_e;

    instr_encoder #(
        .DEPTH     (4),
        .ADDR_W    (8),
        .BASE_ADDR (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_rs      (req_rs),
        .req_rt      (req_rt),
        .req_rd      (req_rd),
        .req_shamt   (req_shamt),
        .req_funct   (req_funct),
        .req_imm     (req_imm),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .wr_count    (wr_count),
        .err_illegal (err_illegal),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every acknowledged write outside flush/reset must match the queue head.
    always @(negedge clk) begin
        if (!reset && !flush && mem_we && mem_ack) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", mem_addr, mem_wdata);
            end else begin
                exp_e = exp_q.pop_front();
                check("write_addr", 64'(mem_addr), 64'(exp_e[39:32]));
                check("write_data", 64'(mem_wdata), 64'(exp_e[31:0]));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] shamt, input logic [5:0] funct,
                        input logic [15:0] imm, input logic [31:0] exp_word);
        int n;
        req_op = op; req_rs = rs; req_rt = rt; req_rd = rd;
        req_shamt = shamt; req_funct = funct; req_imm = imm;
        req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: req_ready stuck at 0 for op %0d", op);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (op < 3'd6) begin
            exp_q.push_back({exp_addr, exp_word});
            exp_addr = exp_addr + 8'd1;
        end
        #1 req_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        exp_q.delete();
        exp_addr = 8'h00;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (busy || exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy=%0d pending=%0d", busy, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", 64'(req_ready), 64'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'h1);
        check("rst_mem_we", 64'(mem_we), 64'h0);
        check("rst_addr", 64'(mem_addr), 64'h0);
        check("rst_wdata", 64'(mem_wdata), 64'h0);
        check("rst_wr_count", 64'(wr_count), 64'h0);
        check("rst_err", 64'(err_illegal), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        @(posedge clk);
        #1;

        // LW latency with ack held high
        mem_ack = 1'b1;
        send(3'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 32'h8FA80004);
        @(negedge clk);
        check("lat_we_n1", 64'(mem_we), 64'h0);
        check("lat_busy_n1", 64'(busy), 64'h1);
        @(negedge clk);
        check("lat_we_n2", 64'(mem_we), 64'h1);
        check("lat_data_n2", 64'(mem_wdata), 64'h8FA80004);
        check("lat_addr_n2", 64'(mem_addr), 64'h00);
        wait_idle();

        // R-type then ORI, back-to-back
        do_flush();
        send(3'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'hBEEF, 32'h012A4020);
        send(3'd5, 5'd0, 5'd8, 5'd31, 5'd7, 6'h3F, 16'h00FF, 32'h340800FF);
        @(negedge clk);
        check("b2b_first_we", 64'(mem_we), 64'h1);
        check("b2b_first_data", 64'(mem_wdata), 64'h012A4020);
        @(negedge clk);
        check("b2b_second_we", 64'(mem_we), 64'h1);
        check("b2b_second_data", 64'(mem_wdata), 64'h340800FF);
        wait_idle();
        check("b2b_wr_count", 64'(wr_count), 64'd2);

        // Back-pressure: ack low until the FIFO and output register fill
        do_flush();
        mem_ack = 1'b0;
        send(3'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFE, 32'h5422FFFE);
        send(3'd3, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'h0003, 32'h10850003);
        send(3'd2, 5'd29, 5'd31, 5'd0, 5'd0, 6'd0, 16'h0008, 32'hAFBF0008);
        send(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0010, 32'h8C220010);
        send(3'd1, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0020, 32'h8C640020);
        @(negedge clk);
        check("bp_ready_low", 64'(req_ready), 64'h0);
        check("bp_we", 64'(mem_we), 64'h1);
        check("bp_hold_data", 64'(mem_wdata), 64'h5422FFFE);
        repeat (3) @(negedge clk);
        check("bp_hold_data_later", 64'(mem_wdata), 64'h5422FFFE);
        check("bp_hold_addr", 64'(mem_addr), 64'h00);
        @(posedge clk);
        #1 mem_ack = 1'b1;
        send(3'd1, 5'd5, 5'd6, 5'd0, 5'd0, 6'd0, 16'h0030, 32'h8CA60030);
        wait_idle();
        check("bp_wr_count", 64'(wr_count), 64'd6);
        check("bp_final_addr", 64'(mem_addr), 64'd6);

        // Illegal op
        send(3'd6, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1234, 32'h0);
        @(negedge clk);
        check("ill_err_pulse", 64'(err_illegal), 64'h1);
        check("ill_no_we", 64'(mem_we), 64'h0);
        @(negedge clk);
        check("ill_err_cleared", 64'(err_illegal), 64'h0);
        check("ill_no_we_later", 64'(mem_we), 64'h0);
        check("ill_busy", 64'(busy), 64'h0);
        check("ill_wr_count", 64'(wr_count), 64'd6);
        @(posedge clk);
        #1;

        // Address wrap and wr_count saturation
        do_flush();
        for (int i = 0; i < 256; i++)
            send(3'd1, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'(i), 32'h8C000000 | 32'(i));
        wait_idle();
        check("wrap_wr_count", 64'(wr_count), 64'd256);
        check("wrap_addr", 64'(mem_addr), 64'h00);
        send(3'd5, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h00FF, 32'h340800FF);
        wait_idle();
        check("sat_wr_count", 64'(wr_count), 64'd256);
        check("sat_addr", 64'(mem_addr), 64'h01);

        // Flush coincident with ack, three words queued behind the output register
        do_flush();
        mem_ack = 1'b0;
        send(3'd1, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0001, 32'h8C000001);
        send(3'd1, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0002, 32'h8C000002);
        send(3'd1, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0003, 32'h8C000003);
        send(3'd1, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0004, 32'h8C000004);
        @(negedge clk);
        check("fl_pre_we", 64'(mem_we), 64'h1);
        check("fl_pre_data", 64'(mem_wdata), 64'h8C000001);
        @(posedge clk);
        #1;
        flush = 1'b1;
        mem_ack = 1'b1;
        exp_q.delete();
        exp_addr = 8'h00;
        @(negedge clk);
        check("fl_ready_low", 64'(req_ready), 64'h0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("fl_we", 64'(mem_we), 64'h0);
        check("fl_addr", 64'(mem_addr), 64'h00);
        check("fl_wr_count", 64'(wr_count), 64'h0);
        check("fl_busy", 64'(busy), 64'h0);
        @(posedge clk);
        #1;
        send(3'd3, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'h0003, 32'h10850003);
        wait_idle();
        check("fl_after_wr_count", 64'(wr_count), 64'd1);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
